dash_cluster_decoder: RTL and testbench
=======================================

DASH_CLUSTER_DECODER -- requirements
Module: dash_cluster_decoder

Interface
REQ-001 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous active-low reset.
REQ-004 rear_lights, rear_blinkers, front_blinkers, front_headlights  in  10 each  lamp patterns from the lighting/transmission controller.
REQ-005 transmission  in  3  gear code: PARK=000, R=111, 1..6=001..110.
REQ-006 fault_clr  in  1  synchronous clear of sticky faults.
REQ-007 turn_ind  out  2  [1]=left, [0]=right indicator lamp.
REQ-008 hazard_ind, brake_ind, reverse_ind  out  1 each  cluster lamps.
REQ-009 beam_ind  out  2  00 off, 01 daytime, 10 low, 11 high.
REQ-010 gear_disp  out  3  last legally reached gear code.
REQ-011 blink_cnt  out  8  completed blink cycles, saturating at 255.
REQ-012 fault  out  4  sticky: [0] illegal pattern, [1] rear sequence violation, [2] illegal gear transition, [3] front/rear blinker mismatch.

Function
REQ-013 SHALL sample all pattern inputs every cycle into a previous-sample register; all outputs registered, 1-cycle latency from input to output.
REQ-014 Legal sets: rear_lights {0x000, 0x186 brake, 0x030 reverse}; rear_blinkers {0x000, R1 0x008, R2 0x00C, R3 0x00E, R4 0x00F, L1 0x040, L2 0x0C0, L3 0x1C0, L4 0x3C0, hazard 0x3CF}; front_blinkers {0x000, 0x00F right, 0x3C0 left, 0x201 hazard}; front_headlights {0x000, 0x020 daytime, 0x010 low, 0x048 high}.
REQ-015 Any input outside its legal set SHALL set fault[0]; corresponding indicators SHALL hold their previous value that cycle.
REQ-016 brake_ind=1 iff rear_lights==0x186; reverse_ind=1 iff rear_lights==0x030.
REQ-017 hazard_ind=1 iff front_blinkers==0x201 or rear_blinkers==0x3CF; turn_ind[0]=1 iff front_blinkers==0x00F; turn_ind[1]=1 iff front_blinkers==0x3C0.
REQ-018 beam_ind decoded from front_headlights per REQ-009.
REQ-019 Rear blinker legal transitions (prev->cur): any->OFF; OFF->{R1,L1,hazard}; R1->R2->R3->R4->R1; L1->L2->L3->L4->L1; self-hold illegal except OFF; violation SHALL set fault[1].
REQ-020 blink_cnt SHALL increment on R4->R1, L4->L1 and OFF->hazard; saturate at 255; no wrap.
REQ-021 Gear legal transitions: same->same; any->PARK; PARK->{1,R}; R->PARK; 1->{2,R}; n->n+1 for 2..5; n->n-1 for 2..6; all others SHALL set fault[2] and leave gear_disp unchanged; legal ones update gear_disp.
REQ-022 fault[3] SHALL set when front_blinkers is right (left) while rear_blinkers is a left (right) sequence pattern, same sample.
REQ-023 First sample after reset SHALL skip transition checks (REQ-019/021) and load gear_disp directly if code legal.
REQ-024 fault_clr SHALL clear fault next edge; a fault detected in the same cycle as fault_clr SHALL win (bit set).

Reset
REQ-025 While RST=0: all outputs 0 (gear_disp=PARK), previous-sample registers 0, first-sample flag set, blink_cnt=0.
REQ-026 Reset asserted mid-sequence SHALL abort immediately; sequence checking restarts per REQ-023.

Structure
REQ-027 Lamp-pattern and gear-code constants SHALL live in shared package body_ctrl_pkg, used by both controller and decoder.
REQ-028 Rear sequence legality and blink counting SHALL be one sub-module, blink_seq_checker.

Verification
REQ-029 Right blinker: rear 0x008,0x00C,0x00E,0x00F,0x008 -> blink_cnt=1, fault=0.
REQ-030 Sequence skip: rear 0x008 then 0x00E -> fault[1]=1 next edge, stays until fault_clr.
REQ-031 Gears PARK,1,2,3,2,1,R,PARK -> gear_disp follows, fault=0; then 1->3 -> fault[2]=1, gear_disp stays 001.
REQ-032 Illegal pattern front_headlights=0x3FF -> fault[0]=1, beam_ind holds prior value.
REQ-033 Hazard: front 0x201, rear 0x3CF -> hazard_ind=1, blink_cnt+1; front 0x00F with rear 0x040 -> fault[3]=1.
REQ-034 Reset mid R3 then first sample 0x00F -> no fault[1]; blink_cnt 255 plus one wrap -> stays 255.

Source files
------------

// File: rtl/body_ctrl_pkg.sv
// Shared lamp-pattern and gear-code constants used by the lighting controller
// and the dash cluster decoder, plus legality helpers built on those constants.
package body_ctrl_pkg;

  // rear_lights patterns
  localparam logic [9:0] RL_OFF     = 10'h000;
  localparam logic [9:0] RL_BRAKE   = 10'h186;
  localparam logic [9:0] RL_REVERSE = 10'h030;

  // rear_blinkers patterns: right sweep R1..R4, left sweep L1..L4, hazard
  localparam logic [9:0] RB_OFF = 10'h000;
  localparam logic [9:0] RB_R1  = 10'h008;
  localparam logic [9:0] RB_R2  = 10'h00C;
  localparam logic [9:0] RB_R3  = 10'h00E;
  localparam logic [9:0] RB_R4  = 10'h00F;
  localparam logic [9:0] RB_L1  = 10'h040;
  localparam logic [9:0] RB_L2  = 10'h0C0;
  localparam logic [9:0] RB_L3  = 10'h1C0;
  localparam logic [9:0] RB_L4  = 10'h3C0;
  localparam logic [9:0] RB_HAZ = 10'h3CF;

  // front_blinkers patterns
  localparam logic [9:0] FB_OFF   = 10'h000;
  localparam logic [9:0] FB_RIGHT = 10'h00F;
  localparam logic [9:0] FB_LEFT  = 10'h3C0;
  localparam logic [9:0] FB_HAZ   = 10'h201;

  // front_headlights patterns
  localparam logic [9:0] FH_OFF  = 10'h000;
  localparam logic [9:0] FH_DAY  = 10'h020;
  localparam logic [9:0] FH_LOW  = 10'h010;
  localparam logic [9:0] FH_HIGH = 10'h048;

  // gear codes; forward gears 1..6 are the plain binary values 001..110
  localparam logic [2:0] GEAR_PARK = 3'b000;
  localparam logic [2:0] GEAR_1    = 3'b001;
  localparam logic [2:0] GEAR_6    = 3'b110;
  localparam logic [2:0] GEAR_R    = 3'b111;

  // fault vector bit positions
  localparam int FLT_PATTERN  = 0;
  localparam int FLT_REAR_SEQ = 1;
  localparam int FLT_GEAR     = 2;
  localparam int FLT_MISMATCH = 3;

  typedef enum logic [1:0] {
    BEAM_OFF  = 2'b00,
    BEAM_DAY  = 2'b01,
    BEAM_LOW  = 2'b10,
    BEAM_HIGH = 2'b11
  } beam_e;

  function automatic logic rear_lights_legal(input logic [9:0] p);
    return (p == RL_OFF) || (p == RL_BRAKE) || (p == RL_REVERSE);
  endfunction

  function automatic logic rear_is_right(input logic [9:0] p);
    return (p == RB_R1) || (p == RB_R2) || (p == RB_R3) || (p == RB_R4);
  endfunction

  function automatic logic rear_is_left(input logic [9:0] p);
    return (p == RB_L1) || (p == RB_L2) || (p == RB_L3) || (p == RB_L4);
  endfunction

  function automatic logic rear_blk_legal(input logic [9:0] p);
    return (p == RB_OFF) || (p == RB_HAZ) || rear_is_right(p) || rear_is_left(p);
  endfunction

  function automatic logic front_blk_legal(input logic [9:0] p);
    return (p == FB_OFF) || (p == FB_RIGHT) || (p == FB_LEFT) || (p == FB_HAZ);
  endfunction

  function automatic logic headlights_legal(input logic [9:0] p);
    return (p == FH_OFF) || (p == FH_DAY) || (p == FH_LOW) || (p == FH_HIGH);
  endfunction

  // Rear sweep step: OFF is always reachable, OFF starts a sweep or hazard,
  // each sweep advances one lamp and wraps; holding any lit pattern is illegal.
  function automatic logic rear_step_legal(input logic [9:0] prev, input logic [9:0] cur);
    if (cur == RB_OFF) return 1'b1;
    case (prev)
      RB_OFF:  return (cur == RB_R1) || (cur == RB_L1) || (cur == RB_HAZ);
      RB_R1:   return cur == RB_R2;
      RB_R2:   return cur == RB_R3;
      RB_R3:   return cur == RB_R4;
      RB_R4:   return cur == RB_R1;
      RB_L1:   return cur == RB_L2;
      RB_L2:   return cur == RB_L3;
      RB_L3:   return cur == RB_L4;
      RB_L4:   return cur == RB_L1;
      default: return 1'b0;
    endcase
  endfunction

  // Gear change: hold, drop to PARK, PARK->1/R, 1->2/R, single up/down steps.
  function automatic logic gear_step_legal(input logic [2:0] from, input logic [2:0] to);
    if ((to == from) || (to == GEAR_PARK)) return 1'b1;
    case (from)
      GEAR_PARK: return (to == GEAR_1) || (to == GEAR_R);
      GEAR_R:    return 1'b0;
      GEAR_1:    return (to == 3'b010) || (to == GEAR_R);
      default:   return ((from != GEAR_6) && (to == from + 3'd1)) || (to == from - 3'd1);
    endcase
  endfunction

endpackage

// File: rtl/dash_cluster_decoder_if.sv
// Bundle of lamp-pattern inputs and cluster indicator outputs between the
// body controller (master) and the dash cluster decoder (slave).
interface dash_cluster_decoder_if;
  logic [9:0] rear_lights;
  logic [9:0] rear_blinkers;
  logic [9:0] front_blinkers;
  logic [9:0] front_headlights;
  logic [2:0] transmission;
  logic       fault_clr;
  logic [1:0] turn_ind;
  logic       hazard_ind;
  logic       brake_ind;
  logic       reverse_ind;
  logic [1:0] beam_ind;
  logic [2:0] gear_disp;
  logic [7:0] blink_cnt;
  logic [3:0] fault;

  modport master (
    output rear_lights, rear_blinkers, front_blinkers, front_headlights,
           transmission, fault_clr,
    input  turn_ind, hazard_ind, brake_ind, reverse_ind, beam_ind,
           gear_disp, blink_cnt, fault
  );

  modport slave (
    input  rear_lights, rear_blinkers, front_blinkers, front_headlights,
           transmission, fault_clr,
    output turn_ind, hazard_ind, brake_ind, reverse_ind, beam_ind,
           gear_disp, blink_cnt, fault
  );
endinterface

// File: rtl/blink_seq_checker.sv
// Tracks the previous rear_blinkers sample, flags illegal sweep steps and
// counts completed blink cycles (saturating).
module blink_seq_checker
  import body_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] rear_blinkers_i,
  input  logic       first_i,
  output logic       seq_viol_o,
  output logic [7:0] blink_cnt_o
);

  logic [9:0] prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic       wrap;

  // Step checks and cycle detection; suppressed on the first sample after
  // reset because prev_q then holds no real history. Out-of-set samples are
  // reported as pattern faults only, not as sequence faults.
  always_comb begin
    seq_viol_o = 1'b0;
    wrap       = 1'b0;
    cnt_d      = cnt_q;
    if (!first_i) begin
      seq_viol_o = rear_blk_legal(rear_blinkers_i) &&
                   !rear_step_legal(prev_q, rear_blinkers_i);
      wrap = ((prev_q == RB_R4)  && (rear_blinkers_i == RB_R1)) ||
             ((prev_q == RB_L4)  && (rear_blinkers_i == RB_L1)) ||
             ((prev_q == RB_OFF) && (rear_blinkers_i == RB_HAZ));
    end
    if (wrap && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  // Previous-sample and blink-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= rear_blinkers_i;
      cnt_q  <= cnt_d;
    end
  end

  assign blink_cnt_o = cnt_q;

endmodule

// File: rtl/dash_cluster_decoder.sv
// Dash cluster decoder: turns raw lamp patterns and gear codes into cluster
// indicators with one cycle of latency, and keeps sticky fault flags.
module dash_cluster_decoder
  import body_ctrl_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  dash_cluster_decoder_if.slave  bus
);

  logic [1:0] turn_q, turn_d;
  logic       hazard_q, hazard_d;
  logic       brake_q, brake_d;
  logic       reverse_q, reverse_d;
  logic [1:0] beam_q, beam_d;
  logic [2:0] gear_q, gear_d;
  logic [3:0] fault_q, fault_d;
  logic       first_q;
  logic       rl_ok, rb_ok, fb_ok, fh_ok;
  logic       seq_viol, gear_flt, mismatch;
  logic [7:0] blink_cnt;

  blink_seq_checker u_seq (
    .clk_i          (CLK),
    .rst_ni         (RST),
    .rear_blinkers_i(bus.rear_blinkers),
    .first_i        (first_q),
    .seq_viol_o     (seq_viol),
    .blink_cnt_o    (blink_cnt)
  );

  // Next-state decode; an out-of-set input freezes the indicators it drives.
  // Gear legality is judged against the last legally reached gear so that a
  // lever parked on an illegal target keeps flagging instead of being adopted.
  always_comb begin
    rl_ok = rear_lights_legal(bus.rear_lights);
    rb_ok = rear_blk_legal(bus.rear_blinkers);
    fb_ok = front_blk_legal(bus.front_blinkers);
    fh_ok = headlights_legal(bus.front_headlights);

    brake_d   = rl_ok ? (bus.rear_lights == RL_BRAKE)   : brake_q;
    reverse_d = rl_ok ? (bus.rear_lights == RL_REVERSE) : reverse_q;
    turn_d    = fb_ok ? {bus.front_blinkers == FB_LEFT, bus.front_blinkers == FB_RIGHT}
                      : turn_q;
    hazard_d  = (fb_ok && rb_ok) ? ((bus.front_blinkers == FB_HAZ) ||
                                    (bus.rear_blinkers == RB_HAZ))
                                 : hazard_q;

    beam_d = beam_q;
    case (bus.front_headlights)
      FH_OFF:  beam_d = BEAM_OFF;
      FH_DAY:  beam_d = BEAM_DAY;
      FH_LOW:  beam_d = BEAM_LOW;
      FH_HIGH: beam_d = BEAM_HIGH;
      default: beam_d = beam_q;
    endcase

    gear_d   = gear_q;
    gear_flt = 1'b0;
    if (first_q || gear_step_legal(gear_q, bus.transmission)) gear_d = bus.transmission;
    else gear_flt = 1'b1;

    mismatch = ((bus.front_blinkers == FB_RIGHT) && rear_is_left(bus.rear_blinkers)) ||
               ((bus.front_blinkers == FB_LEFT)  && rear_is_right(bus.rear_blinkers));

    fault_d = bus.fault_clr ? 4'b0000 : fault_q;
    fault_d[FLT_PATTERN]  = fault_d[FLT_PATTERN]  | ~(rl_ok & rb_ok & fb_ok & fh_ok);
    fault_d[FLT_REAR_SEQ] = fault_d[FLT_REAR_SEQ] | seq_viol;
    fault_d[FLT_GEAR]     = fault_d[FLT_GEAR]     | gear_flt;
    fault_d[FLT_MISMATCH] = fault_d[FLT_MISMATCH] | mismatch;
  end

  // Registered indicator, gear, fault and first-sample state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      turn_q    <= '0;
      hazard_q  <= 1'b0;
      brake_q   <= 1'b0;
      reverse_q <= 1'b0;
      beam_q    <= BEAM_OFF;
      gear_q    <= GEAR_PARK;
      fault_q   <= '0;
      first_q   <= 1'b1;
    end else begin
      turn_q    <= turn_d;
      hazard_q  <= hazard_d;
      brake_q   <= brake_d;
      reverse_q <= reverse_d;
      beam_q    <= beam_d;
      gear_q    <= gear_d;
      fault_q   <= fault_d;
      first_q   <= 1'b0;
    end
  end

  assign bus.turn_ind    = turn_q;
  assign bus.hazard_ind  = hazard_q;
  assign bus.brake_ind   = brake_q;
  assign bus.reverse_ind = reverse_q;
  assign bus.beam_ind    = beam_q;
  assign bus.gear_disp   = gear_q;
  assign bus.blink_cnt   = blink_cnt;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_dash_cluster_decoder.sv
// Bench for dash_cluster_decoder: vector table, directed corner sequences and
// a randomized run against a behavioural model of the cluster rules.
module tb_dash_cluster_decoder;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dash_cluster_decoder_if ifc ();
  dash_cluster_decoder dut (.CLK(CLK), .RST(RST), .bus(ifc));

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] RSEQ [4] = '{10'h008, 10'h00C, 10'h00E, 10'h00F};
  logic [9:0] LSEQ [4] = '{10'h040, 10'h0C0, 10'h1C0, 10'h3C0};
  logic [9:0] RB_SET [10] = '{10'h000, 10'h008, 10'h00C, 10'h00E, 10'h00F,
                              10'h040, 10'h0C0, 10'h1C0, 10'h3C0, 10'h3CF};
  logic [9:0] RL_SET [3] = '{10'h000, 10'h186, 10'h030};
  logic [9:0] FB_SET [4] = '{10'h000, 10'h00F, 10'h3C0, 10'h201};
  logic [9:0] FH_SET [4] = '{10'h000, 10'h020, 10'h010, 10'h048};

  // model state
  logic [1:0] m_turn, m_beam;
  logic       m_haz, m_brake, m_rev, m_first;
  logic [2:0] m_gear;
  logic [3:0] m_fault;
  int         m_cnt;
  logic [9:0] m_prev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit is_r(input logic [9:0] v);
    return v inside {10'h008, 10'h00C, 10'h00E, 10'h00F};
  endfunction
  function automatic bit is_l(input logic [9:0] v);
    return v inside {10'h040, 10'h0C0, 10'h1C0, 10'h3C0};
  endfunction

  function automatic bit rear_ok(input logic [9:0] p, input logic [9:0] c);
    if (c == 10'h000) return 1;
    if (p == 10'h000) return (c == RSEQ[0]) || (c == LSEQ[0]) || (c == 10'h3CF);
    for (int i = 0; i < 4; i++) begin
      if (p == RSEQ[i]) return c == RSEQ[(i + 1) % 4];
      if (p == LSEQ[i]) return c == LSEQ[(i + 1) % 4];
    end
    return 0;
  endfunction

  function automatic int gnum(input logic [2:0] g);
    return (g == 3'b111) ? -1 : int'(g);
  endfunction

  function automatic bit gear_ok(input int f, input int t);
    if (t == f || t == 0) return 1;
    if (f == 0) return (t == 1) || (t == -1);
    if (f == -1) return 0;
    if (f == 1) return (t == 2) || (t == -1);
    return ((f <= 5) && (t == f + 1)) || (t == f - 1);
  endfunction

  task automatic model_reset();
    m_turn = 0; m_beam = 0; m_haz = 0; m_brake = 0; m_rev = 0;
    m_gear = 0; m_fault = 0; m_cnt = 0; m_prev = 0; m_first = 1;
  endtask

  task automatic model_step();
    logic [9:0] rl, rb, fb, fh;
    logic [2:0] tr;
    logic [3:0] flt;
    bit rl_ok, rb_ok, fb_ok, fh_ok;
    rl = ifc.rear_lights; rb = ifc.rear_blinkers; fb = ifc.front_blinkers;
    fh = ifc.front_headlights; tr = ifc.transmission;
    rl_ok = rl inside {10'h000, 10'h186, 10'h030};
    rb_ok = (rb == 10'h000) || (rb == 10'h3CF) || is_r(rb) || is_l(rb);
    fb_ok = fb inside {10'h000, 10'h00F, 10'h3C0, 10'h201};
    fh_ok = fh inside {10'h000, 10'h020, 10'h010, 10'h048};
    flt = 0;
    flt[0] = !(rl_ok && rb_ok && fb_ok && fh_ok);
    if (rl_ok) begin m_brake = (rl == 10'h186); m_rev = (rl == 10'h030); end
    if (fb_ok) m_turn = {fb == 10'h3C0, fb == 10'h00F};
    if (fb_ok && rb_ok) m_haz = (fb == 10'h201) || (rb == 10'h3CF);
    if (fh_ok) m_beam = (fh == 10'h020) ? 2'd1 : (fh == 10'h010) ? 2'd2 :
                        (fh == 10'h048) ? 2'd3 : 2'd0;
    if (!m_first) begin
      if (rb_ok && !rear_ok(m_prev, rb)) flt[1] = 1;
      if ((m_prev == RSEQ[3] && rb == RSEQ[0]) || (m_prev == LSEQ[3] && rb == LSEQ[0]) ||
          (m_prev == 10'h000 && rb == 10'h3CF))
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    if (m_first || gear_ok(gnum(m_gear), gnum(tr))) m_gear = tr;
    else flt[2] = 1;
    flt[3] = (fb == 10'h00F && is_l(rb)) || (fb == 10'h3C0 && is_r(rb));
    m_fault = (ifc.fault_clr ? 4'b0 : m_fault) | flt;
    m_prev = rb;
    m_first = 0;
  endtask

  task automatic check_all(input string nm);
    check({nm, ".turn"},   ifc.turn_ind,    m_turn);
    check({nm, ".hazard"}, ifc.hazard_ind,  m_haz);
    check({nm, ".brake"},  ifc.brake_ind,   m_brake);
    check({nm, ".rev"},    ifc.reverse_ind, m_rev);
    check({nm, ".beam"},   ifc.beam_ind,    m_beam);
    check({nm, ".gear"},   ifc.gear_disp,   m_gear);
    check({nm, ".cnt"},    ifc.blink_cnt,   m_cnt);
    check({nm, ".fault"},  ifc.fault,       m_fault);
  endtask

  task automatic tick(input string nm);
    @(posedge CLK);
    model_step();
    #1;
    check_all(nm);
  endtask

  task automatic drive(input logic [9:0] rl, input logic [9:0] rb, input logic [9:0] fb,
                       input logic [9:0] fh, input logic [2:0] tr, input logic clr);
    ifc.rear_lights = rl; ifc.rear_blinkers = rb; ifc.front_blinkers = fb;
    ifc.front_headlights = fh; ifc.transmission = tr; ifc.fault_clr = clr;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("rst.turn", ifc.turn_ind, 0);   check("rst.gear", ifc.gear_disp, 0);
    check("rst.cnt", ifc.blink_cnt, 0);   check("rst.fault", ifc.fault, 0);
    check("rst.beam", ifc.beam_ind, 0);
    check("rst.misc", {ifc.hazard_ind, ifc.brake_ind, ifc.reverse_ind}, 0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
  endtask

  function automatic logic [9:0] follow_rb(input logic [9:0] p);
    if (p == 10'h000) begin
      case ($urandom_range(0, 2))
        0: return RSEQ[0];
        1: return LSEQ[0];
        default: return 10'h3CF;
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      if (p == RSEQ[i]) return RSEQ[(i + 1) % 4];
      if (p == LSEQ[i]) return LSEQ[(i + 1) % 4];
    end
    return 10'h000;
  endfunction

  typedef struct {
    logic [9:0] rl, rb, fb, fh;
    logic [2:0] tr;
    logic       clr;
    logic [1:0] turn;
    logic       haz, brake, rev;
    logic [1:0] beam;
    logic [2:0] gear;
    logic [7:0] cnt;
    logic [3:0] flt;
  } vec_t;

  vec_t tbl [7];
  logic [2:0] gseq [8];
  logic [9:0] rb_r, fb_r, fh_r, rl_r;
  logic [2:0] tr_r;

  initial begin
    tbl[0] = '{10'h000, 10'h000, 10'h000, 10'h000, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 8'd0, 4'h0};
    tbl[1] = '{10'h186, 10'h000, 10'h00F, 10'h020, 3'd0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 3'd0, 8'd0, 4'h0};
    tbl[2] = '{10'h030, 10'h000, 10'h3C0, 10'h010, 3'd1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 3'd1, 8'd0, 4'h0};
    tbl[3] = '{10'h000, 10'h000, 10'h201, 10'h048, 3'd2, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 3'd2, 8'd0, 4'h0};
    tbl[4] = '{10'h186, 10'h3CF, 10'h000, 10'h000, 3'd2, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 3'd2, 8'd1, 4'h0};
    tbl[5] = '{10'h3FF, 10'h000, 10'h000, 10'h000, 3'd2, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 3'd2, 8'd1, 4'h1};
    tbl[6] = '{10'h000, 10'h000, 10'h000, 10'h000, 3'd2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 3'd2, 8'd1, 4'h0};
    gseq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd7, 3'd0};

    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    do_reset();

    // vector table
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rl, tbl[i].rb, tbl[i].fb, tbl[i].fh, tbl[i].tr, tbl[i].clr);
      tick("tbl");
      check($sformatf("tbl%0d.ind", i),
            {ifc.turn_ind, ifc.hazard_ind, ifc.brake_ind, ifc.reverse_ind, ifc.beam_ind},
            {tbl[i].turn, tbl[i].haz, tbl[i].brake, tbl[i].rev, tbl[i].beam});
      check($sformatf("tbl%0d.gear", i),  ifc.gear_disp, tbl[i].gear);
      check($sformatf("tbl%0d.cnt", i),   ifc.blink_cnt, tbl[i].cnt);
      check($sformatf("tbl%0d.fault", i), ifc.fault,     tbl[i].flt);
    end

    // right sweep with one completed cycle
    do_reset();
    foreach (RSEQ[i]) begin drive(0, RSEQ[i], 0, 0, 0, 0); tick("rsweep"); end
    drive(0, RSEQ[0], 0, 0, 0, 0); tick("rsweep");
    check("rsweep.cnt", ifc.blink_cnt, 1);
    check("rsweep.fault", ifc.fault, 0);

    // skipped sweep step is sticky until cleared
    drive(0, 0, 0, 0, 0, 0); tick("skip");
    drive(0, 10'h008, 0, 0, 0, 0); tick("skip");
    drive(0, 10'h00E, 0, 0, 0, 0); tick("skip");
    check("skip.fault", ifc.fault, 4'b0010);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick("skip_hold");
    check("skip.sticky", ifc.fault, 4'b0010);
    drive(0, 0, 0, 0, 0, 1); tick("skip_clr");
    check("skip.clr", ifc.fault, 0);

    // gear walk, then an illegal skip
    foreach (gseq[i]) begin
      drive(0, 0, 0, 0, gseq[i], 0); tick("gears");
      check($sformatf("gears%0d", i), ifc.gear_disp, gseq[i]);
    end
    check("gears.fault", ifc.fault, 0);
    drive(0, 0, 0, 0, 3'd1, 0); tick("gskip");
    drive(0, 0, 0, 0, 3'd3, 0); tick("gskip");
    check("gskip.fault", ifc.fault, 4'b0100);
    check("gskip.gear", ifc.gear_disp, 3'd1);
    tick("gskip_hold");
    check("gskip.hold", ifc.gear_disp, 3'd1);
    drive(0, 0, 0, 0, 3'd0, 1); tick("gskip_clr");

    // illegal headlight pattern holds beam
    drive(0, 0, 0, 10'h010, 0, 0); tick("beam");
    drive(0, 0, 0, 10'h3FF, 0, 0); tick("beam_bad");
    check("beam.hold", ifc.beam_ind, 2'b10);
    check("beam.fault", ifc.fault, 4'b0001);
    drive(0, 0, 0, 0, 0, 1); tick("beam_clr");

    // hazard counts; front/rear direction mismatch
    drive(0, 10'h3CF, 10'h201, 0, 0, 0); tick("haz");
    check("haz.ind", ifc.hazard_ind, 1);
    check("haz.cnt", ifc.blink_cnt, 2);
    drive(0, 0, 0, 0, 0, 0); tick("haz_off");
    drive(0, 10'h040, 10'h00F, 0, 0, 0); tick("mism");
    check("mism.fault", ifc.fault, 4'b1000);

    // fault_clr loses against a fault detected the same cycle
    drive(10'h3FF, 0, 0, 0, 0, 1); tick("clrwin");
    check("clrwin.fault", ifc.fault, 4'b0001);
    drive(0, 0, 0, 0, 0, 1); tick("clrwin_clr");

    // reset in the middle of a sweep restarts checking
    drive(0, 10'h008, 0, 0, 0, 0); tick("mid");
    drive(0, 10'h00C, 0, 0, 0, 0); tick("mid");
    drive(0, 10'h00E, 0, 0, 0, 0); tick("mid");
    do_reset();
    drive(0, 10'h00F, 0, 0, 0, 0); tick("mid_first");
    check("mid.fault", ifc.fault, 0);

    // blink counter saturation
    drive(0, 0, 0, 0, 0, 0); tick("sat");
    for (int i = 0; i < 257; i++) begin
      drive(0, 10'h3CF, 0, 0, 0, 0); tick("sat");
      drive(0, 10'h000, 0, 0, 0, 0); tick("sat");
    end
    check("sat.cnt", ifc.blink_cnt, 255);
    check("sat.fault", ifc.fault, 0);

    // randomized run against the model
    rb_r = 0; tr_r = 0;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: rb_r = follow_rb(rb_r);
        7, 8: rb_r = RB_SET[$urandom_range(0, 9)];
        default: rb_r = 10'($urandom);
      endcase
      rl_r = ($urandom_range(0, 19) == 0) ? 10'($urandom) : RL_SET[$urandom_range(0, 2)];
      fb_r = ($urandom_range(0, 19) == 0) ? 10'($urandom) : FB_SET[$urandom_range(0, 3)];
      fh_r = ($urandom_range(0, 19) == 0) ? 10'($urandom) : FH_SET[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) < 6) tr_r = $urandom_range(0, 1) ? tr_r + 3'd1 : tr_r - 3'd1;
      else tr_r = 3'($urandom_range(0, 7));
      drive(rl_r, rb_r, fb_r, fh_r, tr_r, $urandom_range(0, 7) == 0);
      if (c == 300) do_reset();
      else tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
